// File: rtl/addsub_result_acc.sv
// addsub_result_acc: accumulates signed adder/subtractor results over a group of
// N_SAMPLES transfers (or until flush) and presents the group total, sample count
// and overflow flag on a registered valid/ready output port.
// Optional feature macro: ACC_SATURATE_EN (clamp accumulator on overflow instead of wrapping).
module addsub_result_acc #(
  parameter int W         = 8,
  parameter int ACC_W     = 16,
  parameter int N_SAMPLES = 8,
  localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cob,
  input  logic [W-1:0]     in_out,
  input  logic             in_sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES);

  state_t state, state_n;

  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] count, count_n;
  logic             ovf, ovf_n;

  logic             xfer;
  logic             close;
  logic             out_hs;
  logic [W:0]       raw;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_add;

  assign xfer   = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Widen the incoming sample: adds are unsigned (carry is magnitude), subs are
  // two's complement with the borrow bit acting as the sign.
  assign raw = {in_cob, in_out};
  assign ext = in_sub ? {{(ACC_W-W-1){raw[W]}}, raw}
                      : {{(ACC_W-W-1){1'b0}}, raw};

  // Signed overflow: operands share a sign and the sum's sign differs from it.
  assign sum     = acc + ext;
  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef ACC_SATURATE_EN
  // Clamp toward the direction of the overflowing operands.
  assign acc_add = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_add = sum;
`endif

  // Next values for accumulator, count and sticky overflow; close marks the
  // edge that finishes the group.
  always_comb begin
    acc_n   = acc;
    count_n = count;
    ovf_n   = ovf;
    close   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          acc_n   = ext;
          count_n = CNT_W'(1);
          ovf_n   = 1'b0;
          close   = flush || (N_SAMPLES == 1);
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_n   = acc_add;
          count_n = count + CNT_W'(1);
          ovf_n   = ovf | add_ovf;
        end
        close = flush || (xfer && (count_n == CNT_LAST));
      end
      DONE: begin
        if (out_ready) begin
          acc_n   = '0;
          count_n = '0;
          ovf_n   = 1'b0;
        end
      end
      default: begin
        acc_n   = '0;
        count_n = '0;
        ovf_n   = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; the unused encoding recovers to IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (xfer) state_n = close ? DONE : ACCUM;
      ACCUM:   if (close) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: samples are refused only while a result is waiting.
  always_comb begin
    in_ready = (state != DONE);
  end

  // Running accumulator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      acc   <= acc_n;
      count <= count_n;
      ovf   <= ovf_n;
    end
  end

  // Registered result port: loads on the closing edge, holds through back-pressure
  // and keeps its data after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_acc   <= acc_n;
      out_count <= count_n;
      out_ovf   <= ovf_n;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_result_acc.sv
// Directed bench for addsub_result_acc with a scoreboard of expected group results.
// A second instance with ACC_W=12 shares all inputs to exercise overflow.
module tb_addsub_result_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_cob = 1'b0;
  logic [7:0]  in_out = '0;
  logic        in_sub = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_acc;
  logic [3:0]  out_count;

  logic        in_ready12, out_valid12, out_ovf12;
  logic [11:0] out_acc12;
  logic [3:0]  out_count12;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] acc;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  addsub_result_acc #(.W(8), .ACC_W(16), .N_SAMPLES(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cob(in_cob), .in_out(in_out), .in_sub(in_sub), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  addsub_result_acc #(.W(8), .ACC_W(12), .N_SAMPLES(8)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_cob(in_cob), .in_out(in_out), .in_sub(in_sub), .flush(flush),
    .out_valid(out_valid12), .out_ready(out_ready), .out_acc(out_acc12),
    .out_count(out_count12), .out_ovf(out_ovf12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer; returns 1 time unit after the accepting edge.
  task automatic send(input logic cob, input logic [7:0] v, input logic sub, input logic fl);
    in_valid = 1'b1; in_cob = cob; in_out = v; in_sub = sub; flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [3:0] c, input logic o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    sb.push_back(e);
  endtask

  // Bounded wait for a result, compare against the scoreboard head, then handshake.
  task automatic take(input string tag);
    exp_t e;
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_acc"}, 32'(out_acc), 32'(e.acc));
      chk({tag, "_count"}, 32'(out_count), 32'(e.cnt));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(out_acc), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: eight adds of 300
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(16'h0960, 4'd8, 1'b0);
      send(1'b1, 8'h2C, 1'b0, 1'b0);
    end
    take("add8");

    // 2: eight subs of -10
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(16'hFFB0, 4'd8, 1'b0);
      send(1'b1, 8'hF6, 1'b1, 1'b0);
    end
    take("sub8");

    // Flush alone in IDLE opens no group
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    chk("idle_flush_valid", 32'(out_valid), 32'd0);
    chk("idle_flush_ready", 32'(in_ready), 32'd1);

    // 3: flush arriving with the third sample
    send(1'b0, 8'd5, 1'b0, 1'b0);
    send(1'b0, 8'd6, 1'b0, 1'b0);
    push_exp(16'd18, 4'd3, 1'b0);
    send(1'b0, 8'd7, 1'b0, 1'b1);

    // 4: back-pressure with a sample offered; nothing is absorbed
    in_valid = 1'b1; in_cob = 1'b0; in_out = 8'h64; in_sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_acc", 32'(out_acc), 32'd18);
      chk("hold_count", 32'(out_count), 32'd3);
    end
    in_valid = 1'b0;
    take("flush3");

    // Next group starts from zero; flush without a transfer closes it
    send(1'b0, 8'd4, 1'b0, 1'b0);
    send(1'b0, 8'd5, 1'b0, 1'b0);
    push_exp(16'd9, 4'd2, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    take("flush_only");

    // 5: eight adds of 510; the 12-bit instance overflows
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(16'h0FF0, 4'd8, 1'b0);
      send(1'b1, 8'hFE, 1'b0, 1'b0);
    end
    chk("ovf12_valid", 32'(out_valid12), 32'd1);
    chk("ovf12_flag", 32'(out_ovf12), 32'd1);
    chk("ovf12_count", 32'(out_count12), 32'd8);
`ifdef ACC_SATURATE_EN
    chk("ovf12_acc", 32'(out_acc12), 32'h7FF);
`else
    chk("ovf12_acc", 32'(out_acc12), 32'hFF0);
`endif
    take("add510");

    // 6: async reset mid-group discards it and clears outputs at once
    for (int i = 0; i < 4; i++) send(1'b0, 8'd1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", 32'(out_acc), 32'd0);
    chk("arst_count", 32'(out_count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ovf", 32'(out_ovf12), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(16'd8, 4'd8, 1'b0);
      send(1'b0, 8'd1, 1'b0, 1'b0);
    end
    take("post_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
